z_result_reg: RTL and testbench

Z_RESULT_REG -- requirements
Module: z_result_reg

---
 rtl/z_result_reg.sv | 127 ++++++++++++
 tb/tb_z_result_reg.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z_result_reg.sv
// Z result register: captures a 2*DATA_W ALU result into Zhigh/Zlow, waiting up to
// TIMEOUT cycles for a late valid strobe. Optional flag registers under Z_RESULT_FLAGS_EN.
module z_result_reg #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  Zin,
  input  logic                  alu_valid,
  input  logic [2*DATA_W-1:0]   alu_result,
  input  logic                  Zlowout,
  input  logic                  Zhighout,
  output logic [DATA_W-1:0]     busout,
  output logic                  z_busy,
  output logic                  z_ready,
  output logic                  z_timeout,
  output logic                  z_zero,
  output logic                  z_neg
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FULL} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   zlow_q, zlow_d;
  logic [DATA_W-1:0]   zhigh_q, zhigh_d;
  logic                tmo_q, tmo_d;
  logic                capture;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    capture = 1'b0;
    if (Zin) begin
      // A new request always restarts, whatever the current state.
      tmo_d = 1'b0;
      if (alu_valid) begin
        capture = 1'b1;
        state_d = S_FULL;
      end else begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
    end else if (state_q == S_WAIT) begin
      if (alu_valid) begin
        capture = 1'b1;
        state_d = S_FULL;
      end else if (cnt_q == CNT_LAST) begin
        state_d = S_FULL;
        tmo_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    zlow_d  = zlow_q;
    zhigh_d = zhigh_q;
    if (capture) begin
      zlow_d  = alu_result[DATA_W-1:0];
      zhigh_d = alu_result[2*DATA_W-1:DATA_W];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      zlow_q  <= '0;
      zhigh_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      zlow_q  <= zlow_d;
      zhigh_q <= zhigh_d;
      tmo_q   <= tmo_d;
    end
  end

`ifdef Z_RESULT_FLAGS_EN
  logic zero_q, zero_d;
  logic neg_q, neg_d;

  always_comb begin
    zero_d = zero_q;
    neg_d  = neg_q;
    if (capture) begin
      zero_d = (alu_result == '0);
      neg_d  = alu_result[2*DATA_W-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  end

  assign z_zero = zero_q;
  assign z_neg  = neg_q;
`else
  assign z_zero = 1'b0;
  assign z_neg  = 1'b0;
`endif

  always_comb begin
    busout = '0;
    if (Zlowout)       busout = zlow_q;
    else if (Zhighout) busout = zhigh_q;
  end

  assign z_busy    = (state_q == S_WAIT);
  assign z_ready   = (state_q == S_FULL);
  assign z_timeout = tmo_q;

endmodule

// File: tb/tb_z_result_reg.sv
// Bench for z_result_reg: two instances (TIMEOUT=64 and TIMEOUT=4) share stimulus
// and are compared against a transaction-level reference model.
module tb_z_result_reg;

  logic        clock = 1'b0;
  logic        reset, Zin, alu_valid, Zlowout, Zhighout;
  logic [63:0] alu_result;
  logic [31:0] busout [2];
  logic        z_busy [2], z_ready [2], z_timeout [2], z_zero [2], z_neg [2];

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  z_result_reg #(.DATA_W(32), .TIMEOUT(64)) dut0 (
    .clock(clock), .reset(reset), .Zin(Zin), .alu_valid(alu_valid), .alu_result(alu_result),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .busout(busout[0]), .z_busy(z_busy[0]),
    .z_ready(z_ready[0]), .z_timeout(z_timeout[0]), .z_zero(z_zero[0]), .z_neg(z_neg[0]));

  z_result_reg #(.DATA_W(32), .TIMEOUT(4)) dut1 (
    .clock(clock), .reset(reset), .Zin(Zin), .alu_valid(alu_valid), .alu_result(alu_result),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .busout(busout[1]), .z_busy(z_busy[1]),
    .z_ready(z_ready[1]), .z_timeout(z_timeout[1]), .z_zero(z_zero[1]), .z_neg(z_neg[1]));

  // Reference model: mode 0=idle, 1=waiting for result, 2=holding result.
  int          tout   [2] = '{64, 4};
  int          m_mode [2];
  int          m_wait [2];
  logic [63:0] m_held [2];
  logic        m_tmo [2], m_zero [2], m_neg [2];

  task automatic model_capture(input int i);
    m_held[i] = alu_result;
    m_mode[i] = 2;
`ifdef Z_RESULT_FLAGS_EN
    m_zero[i] = (alu_result == 64'd0);
    m_neg[i]  = alu_result[63];
`endif
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_mode[i] = 0; m_wait[i] = 0; m_held[i] = '0;
        m_tmo[i] = 0; m_zero[i] = 0; m_neg[i] = 0;
      end else if (Zin) begin
        m_tmo[i] = 0;
        if (alu_valid) model_capture(i);
        else begin m_mode[i] = 1; m_wait[i] = 0; end
      end else if (m_mode[i] == 1) begin
        if (alu_valid) model_capture(i);
        else if (m_wait[i] == tout[i] - 1) begin m_mode[i] = 2; m_tmo[i] = 1; end
        else m_wait[i]++;
      end
    end
  endtask

  function automatic logic [4:0] exp_status(input int i);
    return {m_mode[i] == 1, m_mode[i] == 2, m_tmo[i], m_zero[i], m_neg[i]};
  endfunction

  function automatic logic [31:0] exp_bus(input int i);
    if (Zlowout)  return m_held[i][31:0];
    if (Zhighout) return m_held[i][63:32];
    return 32'd0;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; Zin = 0; alu_valid = 0; alu_result = '0; Zlowout = 0; Zhighout = 0;
    tick(); tick();
    reset = 0; Zlowout = 1; #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({busout[i], z_ready[i], z_busy[i], z_timeout[i], z_zero[i], z_neg[i]} !== {32'd0, 5'd0}) begin
        errors++;
        $display("FAIL reset_state inst%0d: bus=%h rdy=%b busy=%b tmo=%b zero=%b neg=%b, want all 0",
                 i, busout[i], z_ready[i], z_busy[i], z_timeout[i], z_zero[i], z_neg[i]);
      end
    end
    Zlowout = 0;
  endtask

  task automatic test_capture();
    Zin = 1; alu_valid = 1; alu_result = 64'h0000_0001_8000_0000;
    tick();
    Zin = 0; alu_valid = 0; alu_result = '0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({z_ready[i], z_busy[i], z_zero[i], z_neg[i]} !== 4'b1000) begin
        errors++;
        $display("FAIL capture_status inst%0d: rdy/busy/zero/neg=%b%b%b%b want 1000",
                 i, z_ready[i], z_busy[i], z_zero[i], z_neg[i]);
      end
    end
    Zlowout = 1; #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (busout[i] !== 32'h8000_0000) begin
        errors++; $display("FAIL capture_zlow inst%0d: got %h want 80000000", i, busout[i]);
      end
    end
    Zlowout = 0; Zhighout = 1; #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (busout[i] !== 32'h0000_0001) begin
        errors++; $display("FAIL capture_zhigh inst%0d: got %h want 00000001", i, busout[i]);
      end
    end
    Zhighout = 0;
  endtask

  task automatic test_wait_capture();
    Zin = 1; alu_valid = 0; alu_result = 64'h1234_5678_9abc_def0;
    tick();
    Zin = 0; Zlowout = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (z_busy[0] !== 1'b1 || busout[0] !== 32'h8000_0000) begin
        errors++;
        $display("FAIL wait_busy cycle%0d: busy=%b bus=%h want 1 80000000", k, z_busy[0], busout[0]);
      end
      checks++;
      if ({z_busy[1], z_ready[1], z_timeout[1], z_zero[1], z_neg[1]} !== exp_status(1)) begin
        errors++;
        $display("FAIL wait_inst1 cycle%0d: status=%b%b%b%b%b want %b", k,
                 z_busy[1], z_ready[1], z_timeout[1], z_zero[1], z_neg[1], exp_status(1));
      end
      if (k < 4) tick();
    end
    alu_valid = 1; alu_result = 64'hFFFF_FFFF_0000_0000;
    tick();
    alu_valid = 0; Zlowout = 0; Zhighout = 1; #1;
    checks++;
`ifdef Z_RESULT_FLAGS_EN
    if ({z_ready[0], z_busy[0], z_neg[0], z_zero[0], busout[0]} !== {4'b1010, 32'hFFFF_FFFF}) begin
`else
    if ({z_ready[0], z_busy[0], z_neg[0], z_zero[0], busout[0]} !== {4'b1000, 32'hFFFF_FFFF}) begin
`endif
      errors++;
      $display("FAIL wait_capture inst0: rdy=%b busy=%b neg=%b zero=%b zhigh=%h",
               z_ready[0], z_busy[0], z_neg[0], z_zero[0], busout[0]);
    end
    // inst1 timed out earlier, so the late valid must have been ignored.
    checks++;
    if (busout[1] !== 32'h0000_0001 || z_timeout[1] !== 1'b1) begin
      errors++;
      $display("FAIL late_valid_ignored inst1: zhigh=%h tmo=%b want 00000001 1", busout[1], z_timeout[1]);
    end
    Zhighout = 0;
  endtask

  task automatic test_timeout();
    Zin = 1; alu_valid = 0; alu_result = 64'hDEAD_BEEF_CAFE_F00D;
    tick();
    Zin = 0; Zlowout = 1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (z_ready[1] !== (c == 4) || z_timeout[1] !== (c == 4) || z_busy[1] !== (c != 4)
          || busout[1] !== 32'h8000_0000) begin
        errors++;
        $display("FAIL timeout inst1 c=%0d: rdy=%b tmo=%b busy=%b zlow=%h", c,
                 z_ready[1], z_timeout[1], z_busy[1], busout[1]);
      end
    end
    checks++;
    if (z_busy[0] !== 1'b1 || z_timeout[0] !== 1'b0) begin
      errors++; $display("FAIL timeout inst0 still waiting: busy=%b tmo=%b", z_busy[0], z_timeout[0]);
    end
    Zin = 1; alu_valid = 1; alu_result = 64'h0000_0002_0000_0003;
    tick();
    Zin = 0; alu_valid = 0; #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (z_timeout[i] !== 1'b0 || z_ready[i] !== 1'b1 || busout[i] !== 32'h3) begin
        errors++;
        $display("FAIL timeout_clear inst%0d: tmo=%b rdy=%b zlow=%h", i, z_timeout[i], z_ready[i], busout[i]);
      end
    end
    Zlowout = 0;
  endtask

  task automatic test_restart();
    Zin = 1; alu_valid = 0;
    tick();
    Zin = 0; tick(); tick();
    Zin = 1; tick();
    Zin = 0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (z_busy[1] !== (c != 4) || z_timeout[1] !== (c == 4)) begin
        errors++;
        $display("FAIL restart inst1 c=%0d: busy=%b tmo=%b", c, z_busy[1], z_timeout[1]);
      end
    end
  endtask

  task automatic test_read_priority();
    Zin = 1; alu_valid = 1; alu_result = 64'hAAAA_5555_1234_ABCD;
    tick();
    Zin = 0; alu_valid = 0; Zlowout = 1; Zhighout = 1; #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (busout[i] !== 32'h1234_ABCD) begin
        errors++; $display("FAIL read_both inst%0d: got %h want 1234abcd", i, busout[i]);
      end
    end
    Zlowout = 0; Zhighout = 0; #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (busout[i] !== 32'd0) begin
        errors++; $display("FAIL read_none inst%0d: got %h want 0", i, busout[i]);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    Zin = 1; alu_valid = 0; alu_result = 64'h7777_6666_5555_4444;
    tick();
    Zin = 0; tick();
    reset = 1; alu_valid = 1; tick();
    reset = 0; tick();
    alu_valid = 0;
    for (int i = 0; i < 2; i++) begin
      Zlowout = 1; Zhighout = 0; #1;
      checks++;
      if ({z_busy[i], z_ready[i], z_timeout[i], busout[i]} !== 35'd0) begin
        errors++;
        $display("FAIL reset_mid_wait inst%0d: busy=%b rdy=%b tmo=%b zlow=%h",
                 i, z_busy[i], z_ready[i], z_timeout[i], busout[i]);
      end
      Zlowout = 0; Zhighout = 1; #1;
      checks++;
      if (busout[i] !== 32'd0) begin
        errors++; $display("FAIL reset_mid_wait_zhigh inst%0d: got %h want 0", i, busout[i]);
      end
    end
    Zhighout = 0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(0, 39) == 0);
      Zin       = ($urandom_range(0, 7) == 0);
      alu_valid = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0:       alu_result = 64'd0;
        1:       alu_result = {1'b1, 31'($urandom), 32'($urandom)};
        default: alu_result = {32'($urandom), 32'($urandom)};
      endcase
      Zlowout  = $urandom_range(0, 1);
      Zhighout = $urandom_range(0, 1);
      #1;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (busout[i] !== exp_bus(i)) begin
          errors++; $display("FAIL rand_bus n=%0d inst%0d: got %h want %h", n, i, busout[i], exp_bus(i));
        end
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({z_busy[i], z_ready[i], z_timeout[i], z_zero[i], z_neg[i]} !== exp_status(i)) begin
          errors++;
          $display("FAIL rand_status n=%0d inst%0d: got %b%b%b%b%b want %b", n, i,
                   z_busy[i], z_ready[i], z_timeout[i], z_zero[i], z_neg[i], exp_status(i));
        end
      end
    end
    reset = 0; Zin = 0; alu_valid = 0;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_wait_capture();
    test_timeout();
    test_restart();
    test_read_priority();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
